// File: rtl/cs_decipher.sv
// CS-Cipher 64-bit block decryption core: AXI-Stream in/out, one inverse round per
// clock, round keys regenerated on reset or rekey and held stable while a block is in flight.

module inv_round (
  input  logic [63:0] data_in,
  input  logic [63:0] subkey,
  output logic [63:0] data_out
);
  localparam logic [31:0] MIX_C = 32'h9e3779b9;

  logic [31:0] a, b, a2, b2;

  // Undo the forward mix: the xor half first, then the modular-add half.
  always_comb begin
    a2       = data_in[63:32];
    b2       = data_in[31:0];
    a        = a2 ^ {b2[24:0], b2[31:25]};
    b        = b2 - ({a[28:0], a[31:29]} ^ MIX_C);
    data_out = {a, b} ^ subkey;
  end
endmodule

module key_sh #(
  parameter int NROUNDS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_key_gen,
  input  logic [127:0]                master_key,
  output logic [64*(NROUNDS+1)-1:0]   round_keys,
  output logic                        keys_ready
);
  logic         gen;
  logic [3:0]   idx;
  logic [127:0] t;

  // keys_ready falls whenever start is withdrawn, so a later start never sees a stale done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen        <= 1'b0;
      idx        <= '0;
      keys_ready <= 1'b0;
    end else if (!start_key_gen) begin
      gen        <= 1'b0;
      keys_ready <= 1'b0;
    end else if (!gen && !keys_ready) begin
      gen <= 1'b1;
      idx <= '0;
    end else if (gen) begin
      if (idx == 4'(NROUNDS)) begin
        gen        <= 1'b0;
        keys_ready <= 1'b1;
      end else begin
        idx <= idx + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start_key_gen && !gen && !keys_ready) begin
      t <= master_key;
    end else if (gen) begin
      round_keys[64*idx +: 64] <= t[127:64] ^ {t[50:0], t[63:51]} ^ {16{idx}};
      t                        <= {t[63:0], t[127:64] + t[63:0]};
    end
  end
endmodule

module cs_decipher #(
  parameter int NROUNDS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_axis_tvalid,
  input  logic [63:0]  s_axis_tdata,
  output logic         s_axis_tready,
  output logic         m_axis_tvalid,
  output logic [63:0]  m_axis_tdata,
  input  logic         m_axis_tready,
  input  logic [127:0] master_key,
  input  logic         rekey,
  output logic         busy
);
  localparam int CTR_W = $clog2(NROUNDS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    KEY_GEN = 3'd1,
    READY   = 3'd2,
    ROUNDS  = 3'd3,
    OUTPUT  = 3'd4
  } state_t;

  state_t                     state, state_nxt;
  logic [CTR_W-1:0]           round_counter, ctr_nxt;
  logic [63:0]                state_reg, sreg_nxt;
  logic                       rekey_pending, pend_nxt;
  logic                       start_key_gen, start_nxt;
  logic                       tvalid_nxt, tready_nxt;
  logic [63:0]                tdata_nxt;
  logic [64*(NROUNDS+1)-1:0]  round_keys;
  logic                       keys_ready;
  logic [63:0]                subkey, round_out;

  key_sh #(.NROUNDS(NROUNDS)) u_key_sh (
    .clk           (clk),
    .rst           (rst),
    .start_key_gen (start_key_gen),
    .master_key    (master_key),
    .round_keys    (round_keys),
    .keys_ready    (keys_ready)
  );

  assign subkey = round_keys[64*round_counter +: 64];

  inv_round u_inv_round (
    .data_in  (state_reg),
    .subkey   (subkey),
    .data_out (round_out)
  );

  assign busy = (state != READY);

  always_comb begin
    state_nxt  = state;
    ctr_nxt    = round_counter;
    sreg_nxt   = state_reg;
    pend_nxt   = rekey_pending;
    start_nxt  = start_key_gen;
    tvalid_nxt = m_axis_tvalid;
    tdata_nxt  = m_axis_tdata;
    if (rekey && state != IDLE && state != KEY_GEN) pend_nxt = 1'b1;
    case (state)
      IDLE: begin
        state_nxt = KEY_GEN;
        start_nxt = 1'b1;
        pend_nxt  = 1'b0;
      end
      KEY_GEN: begin
        if (keys_ready) begin
          state_nxt = READY;
          start_nxt = 1'b0;
        end
      end
      READY: begin
        if (rekey_pending) begin
          state_nxt = KEY_GEN;
          start_nxt = 1'b1;
          pend_nxt  = 1'b0;
        end else if (s_axis_tvalid && s_axis_tready) begin
          sreg_nxt  = s_axis_tdata ^ round_keys[64*NROUNDS +: 64];
          ctr_nxt   = CTR_W'(NROUNDS - 1);
          state_nxt = ROUNDS;
        end
      end
      ROUNDS: begin
        sreg_nxt = round_out;
        if (round_counter == '0) begin
          state_nxt  = OUTPUT;
          tvalid_nxt = 1'b1;
          tdata_nxt  = round_out;
        end else begin
          ctr_nxt = round_counter - 1'b1;
        end
      end
      OUTPUT: begin
        if (m_axis_tready) begin
          state_nxt  = READY;
          tvalid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    tready_nxt = (state_nxt == READY) && !pend_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      round_counter <= '0;
      state_reg     <= '0;
      rekey_pending <= 1'b0;
      start_key_gen <= 1'b0;
      s_axis_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      state         <= state_nxt;
      round_counter <= ctr_nxt;
      state_reg     <= sreg_nxt;
      rekey_pending <= pend_nxt;
      start_key_gen <= start_nxt;
      s_axis_tready <= tready_nxt;
      m_axis_tvalid <= tvalid_nxt;
      m_axis_tdata  <= tdata_nxt;
    end
  end
endmodule
